// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a circular receive FIFO and sticky frame/overrun flags.
// state | meaning: IDLE wait for start edge, START mid-start check, DATA 8 bits LSB first, STOP stop-bit check
module uart_rx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_err,
  output logic                          busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] HALF_LD = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_LD = 16'(CLK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    rst_sync_q;
  logic          rst_int_n;
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          frame_err_q, overrun_q;
  logic          push_req, bad_stop, full, do_push, do_pop, drop;

  // Assert asynchronously, release on a clock edge so no flop sees a runt recovery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // A start needs a 1->0 edge, so a held-low break never retriggers until the line goes high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LD;
        end
      end
      START: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rx_s_q) begin
          state_d = IDLE;
        end else begin
          state_d   = DATA;
          cnt_d     = FULL_LD;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL_LD;
          if (bit_idx_q == 3'd7) begin
            state_d   = STOP;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          state_d  = IDLE;
          push_req = rx_s_q;
          bad_stop = !rx_s_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = rx_valid && rx_ready;
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (bad_stop)     frame_err_q <= 1'b1;
      else if (clr_err) frame_err_q <= 1'b0;
      if (drop)         overrun_q <= 1'b1;
      else if (clr_err) overrun_q <= 1'b0;
    end
  end

  assign rx_valid   = (count_q != '0);
  assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLK_DIV=8, FIFO_DEPTH=4.
module tb_uart_rx_fifo;

  localparam int CLK_DIV    = 8;
  localparam int FIFO_DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Start bit goes out just after a rising edge P0; the stop sample lands on edge P79,
  // so the byte must be absent at P78+1 and present at P79+1.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit chk_time,
                            input bit pop_at_stop);
    logic v;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stop_ok;
      else             v = b[i-1];
      rx = v;
      for (int j = 0; j < CLK_DIV; j++) begin
        @(posedge clk); #1;
        if (i == 9 && j == 5) begin
          if (chk_time) chk("valid_before_stop", 32'(rx_valid), 0);
          if (pop_at_stop) rx_ready = 1'b1;
        end
        if (i == 9 && j == 6) begin
          if (chk_time) begin
            chk("valid_after_stop", 32'(rx_valid), 1);
            chk("data_after_stop", 32'(rx_data), 32'(b));
          end
          if (pop_at_stop) rx_ready = 1'b0;
        end
      end
    end
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pop_one(input logic [7:0] exp);
    chk("pop_data", 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  logic [7:0] partial;

  initial begin
    rx       = 1'b1;
    rx_ready = 1'b0;
    clr_err  = 1'b0;
    rst_n    = 1'b0;
    #23;
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({frame_err, overrun}), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Two back-to-back bytes with the consumer always ready.
    rx_ready = 1'b1;
    send_frame(8'h3D, 1'b1, 1'b1, 1'b0);
    chk("t1_count_a", 32'(fifo_count), 0);
    send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
    chk("t1_count_b", 32'(fifo_count), 0);
    chk("t1_flags", 32'({frame_err, overrun}), 0);
    rx_ready = 1'b0;

    // Overflow: fifth byte is dropped.
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0, 1'b0);
    chk("t2_count", 32'(fifo_count), 4);
    chk("t2_overrun", 32'(overrun), 1);
    chk("t2_frame_err", 32'(frame_err), 0);
    for (int k = 1; k <= 4; k++) pop_one(8'(k));
    chk("t2_empty", 32'(rx_valid), 0);
    pulse_clr;
    chk("t2_overrun_clr", 32'(overrun), 0);

    // Full FIFO with a pop coinciding with the push.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0, 1'b0);
    chk("t3_full", 32'(fifo_count), 4);
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    chk("t3_count", 32'(fifo_count), 4);
    chk("t3_overrun", 32'(overrun), 0);
    pop_one(8'h22);
    pop_one(8'h33);
    pop_one(8'h44);
    pop_one(8'h55);
    chk("t3_empty", 32'(fifo_count), 0);

    // Bad stop bit then a good frame.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t4_frame_err", 32'(frame_err), 1);
    chk("t4_count_bad", 32'(fifo_count), 0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("t4_count_good", 32'(fifo_count), 1);
    pop_one(8'h5A);
    chk("t4_overrun", 32'(overrun), 0);
    pulse_clr;
    chk("t4_frame_err_clr", 32'(frame_err), 0);

    // Three-cycle glitch is rejected at the mid-start check.
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rx = 1'b1;
    chk("t5_busy_start", 32'(busy), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_busy_idle", 32'(busy), 0);
    chk("t5_count", 32'(fifo_count), 0);
    chk("t5_flags", 32'({frame_err, overrun}), 0);

    // Reset mid-frame with a byte already queued.
    send_frame(8'h77, 1'b1, 1'b0, 1'b0);
    chk("t6_preload", 32'(fifo_count), 1);
    partial = 8'hC3;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (CLK_DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx = partial[i];
      repeat (CLK_DIV) @(posedge clk);
      #1;
    end
    rx = partial[4];
    repeat (4) @(posedge clk);
    #1;
    chk("t6_busy_mid", 32'(busy), 1);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    chk("t6_rst_count", 32'(fifo_count), 0);
    chk("t6_rst_valid", 32'(rx_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_data", 32'(rx_data), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    chk("t6_count", 32'(fifo_count), 1);
    chk("t6_data", 32'(rx_data), 8'h81);
    chk("t6_flags", 32'({frame_err, overrun}), 0);
    pop_one(8'h81);
    chk("t6_empty", 32'(rx_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_DIV, default 434: clock cycles per UART bit (115200 baud at 50 MHz); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: receive FIFO entries; power of two, range 2..16.
REQ-003 clk  input  1: single clock; all logic is rising-edge triggered.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 rx  input  1: serial line from pad (mprj_io[5]); asynchronous; idles high.
REQ-006 rx_data  output  8: byte at the FIFO head; valid only while rx_valid=1.
REQ-007 rx_valid  output  1: FIFO not empty.
REQ-008 rx_ready  input  1: consumer pop; a pop occurs on any cycle where rx_valid=1 and rx_ready=1.
REQ-009 fifo_count  output  $clog2(FIFO_DEPTH)+1: current number of FIFO entries.
REQ-010 frame_err  output  1: sticky flag; a stop bit was sampled low.
REQ-011 overrun  output  1: sticky flag; a good byte was dropped because the FIFO was full.
REQ-012 clr_err  input  1: synchronous one-cycle clear of frame_err and overrun.
REQ-013 busy  output  1: receiver FSM is not in IDLE.

Function
REQ-014 rx shall pass through a 2-flop synchronizer reset to 1; all FSM decisions shall use the synchronized value (rx_s).
REQ-015 FSM states shall be IDLE, START, DATA, STOP; a cycle counter (0..CLK_DIV-1) and a bit index (0..7) shall time sampling.
REQ-016 IDLE: on a 1->0 transition of rx_s, go to START and load the counter to time CLK_DIV/2 cycles (integer division).
REQ-017 START: at mid-bit, if rx_s=1 (false start), return to IDLE with no flag change; if rx_s=0, go to DATA and time CLK_DIV cycles.
REQ-018 DATA: sample rx_s every CLK_DIV cycles into a shift register, LSB first; after the 8th sample go to STOP and time CLK_DIV cycles.
REQ-019 STOP, rx_s=1 at mid-bit: push the byte into the FIFO and go to IDLE.
REQ-020 STOP, rx_s=0 at mid-bit: discard the byte, set frame_err, and go to IDLE.
REQ-021 After a frame error, IDLE shall not accept a new start until rx_s has been observed high for at least one cycle (break protection).
REQ-022 A pushed byte shall appear on rx_data/rx_valid on the cycle after the stop-bit sample cycle.
REQ-023 Push into a full FIFO with no simultaneous pop: drop the new byte, set overrun, and leave FIFO contents unchanged.
REQ-024 Push and pop in the same cycle while full: both shall occur; count is unchanged; overrun is not set.
REQ-025 Push while empty: rx_valid=0 that cycle, so no pop can occur; count goes 0->1.
REQ-026 The FIFO shall be circular: read and write pointers wrap modulo FIFO_DEPTH; fifo_count shall equal writes minus pops, in the range 0..FIFO_DEPTH.
REQ-027 Bytes shall leave the FIFO in arrival order; rx_data shall be stable while rx_valid=1 and rx_ready=0.
REQ-028 clr_err asserted in the same cycle as a new error event: the error shall win and the flag stays 1.
REQ-029 clr_err shall not affect FIFO contents or FSM state.
REQ-030 busy shall be 1 in START, DATA and STOP, and 0 in IDLE.

Reset
REQ-031 rst_n=0 shall immediately force the following values:
- FSM=IDLE, counter=0, bit index=0
- FIFO pointers=0, fifo_count=0
- rx_valid=0, rx_data=8'h00
- frame_err=0, overrun=0, busy=0
- synchronizer flops=1
REQ-032 Reset asserted mid-frame shall abandon the frame with no push and no flag; after release, reception of the next full frame shall be correct.
REQ-033 Reset release shall be synchronized internally so that the first active edge follows deassertion cleanly.

Verification (CLK_DIV=8, FIFO_DEPTH=4 unless stated)
REQ-034 Send 0x3D then 0x0F, rx_ready=1 -> rx_data 0x3D then 0x0F; each byte valid one cycle after its stop-bit sample; no flags set.
REQ-035 Send 5 bytes 0x01..0x05 with rx_ready=0 -> fifo_count=4, overrun=1; popping returns 0x01..0x04; pulse clr_err -> overrun=0.
REQ-036 Send 0xA5 with stop bit low, then a good 0x5A -> frame_err=1, only 0x5A enters the FIFO.
REQ-037 Drive a 3-cycle low glitch on rx -> false start; FSM returns to IDLE; fifo_count=0; no flags set.
REQ-038 FIFO full, pop asserted on the stop-sample push cycle -> count stays 4, overrun=0, order preserved.
REQ-039 Assert rst_n=0 during bit 4 of 0xC3, release, then send 0x81 -> FIFO holds only 0x81; all flags 0.
